// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  // Controller states: waiting for operands, stepping digits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the digit counter; never narrower than one bit so N == 1 still
  // has a real register.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit subtract with borrow: {bo, d} = x - y - bi.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  // One extra bit catches the borrow: the result goes negative exactly when
  // x < y + bi, and the smallest possible value (-2^DIGIT) still sets it.
  logic [DIGIT:0] r;

  assign r  = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
  assign d  = r[DIGIT-1:0];
  assign bo = r[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH/DIGIT cycles,
// LSB digit first, with borrow-out and signed overflow, valid/ready on both
// sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave sif
);

  localparam int N   = WIDTH / DIGIT;
  localparam int CW  = cnt_width(N);
  localparam int MSB = WIDTH - 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] x;
  logic [DIGIT-1:0] y;
  logic [DIGIT-1:0] d;
  logic             bo;
  logic [WIDTH-1:0] acc_nx;
  logic             last;

  // Select operand digit cnt for the shared digit subtractor.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    x = '0;
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        x = a_q[i*DIGIT +: DIGIT];
        y = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x  (x),
    .y  (y),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  // Accumulator with this cycle's digit merged into slice cnt.
  always_comb begin
    acc_nx = acc;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        acc_nx[i*DIGIT +: DIGIT] = d;
      end
    end
  end

  assign last = (cnt == CW'(N - 1));

  // Controller, digit counter, operand/accumulator registers and result flags.
  // The published diff/bout/ovf live in their own registers so they keep the
  // previous result while a new operation accumulates.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: datapath registers are reset along with the FSM so the outputs read
  // zero after reset and an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      acc    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.in_valid) begin
            a_q    <= sif.a;
            b_q    <= sif.b;
            borrow <= sif.bin;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          borrow <= bo;
          if (last) begin
            diff_q <= acc_nx;
            bout_q <= bo;
            ovf_q  <= (a_q[MSB] != b_q[MSB]) && (acc_nx[MSB] != a_q[MSB]);
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (sif.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode from registered state only.
  assign sif.in_ready  = (state == IDLE);
  assign sif.out_valid = (state == DONE);
  assign sif.busy      = (state != IDLE);
  assign sif.diff      = diff_q;
  assign sif.bout      = bout_q;
  assign sif.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=16, DIGIT=4.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   mode;      // 0: always ready, 1: random stall, 2: hold out_ready low
  exp_t q[$];
  exp_t mon_e;

  serial_subtractor_if #(.WIDTH(16)) sif ();

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    e.diff = full[15:0];
    e.bout = full[16];
    e.ovf  = (a[15] != b[15]) && (e.diff[15] != a[15]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.ovf  = ov;
    return e;
  endfunction

  // Present operands until accepted; push the expected result on acceptance.
  // Returns one time step after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input bit push, input exp_t e);
    int budget;
    budget = 0;
    @(posedge clk);
    #1;
    sif.in_valid = 1'b1;
    sif.a        = a;
    sif.b        = b;
    sif.bin      = bin;
    @(negedge clk);
    while (!sif.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!sif.in_ready) begin
      check("accept_timeout", 32'(sif.in_ready), 32'd1);
      sif.in_valid = 1'b0;
      return;
    end
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Consumer-ready driver.
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = ($urandom_range(0, 3) != 0);
        default: sif.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every delivered result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.out_valid && q.size() == 0) begin
        check("unexpected_out_valid", 32'(sif.out_valid), 32'd0);
      end else if (sif.out_valid && sif.out_ready) begin
        mon_e = q.pop_front();
        check("diff", 32'(sif.diff), 32'(mon_e.diff));
        check("bout", 32'(sif.bout), 32'(mon_e.bout));
        check("ovf",  32'(sif.ovf),  32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   t;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;

    n_checks     = 0;
    n_errors     = 0;
    mode         = 0;
    rst_n        = 1'b0;
    sif.in_valid = 1'b0;
    sif.a        = '0;
    sif.b        = '0;
    sif.bin      = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready",  32'(sif.in_ready),  32'd1);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_busy",      32'(sif.busy),      32'd0);
    check("rst_diff",      32'(sif.diff),      32'd0);
    check("rst_bout",      32'(sif.bout),      32'd0);
    check("rst_ovf",       32'(sif.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First vector with latency measurement.
    issue(16'h1234, 16'h0034, 1'b0, 1, mk(16'h1200, 1'b0, 1'b0));
    lat = 0;
    @(negedge clk);
    check("run_in_ready", 32'(sif.in_ready), 32'd0);
    check("run_busy",     32'(sif.busy),     32'd1);
    while (!sif.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'd4);
    drain();

    // Directed vectors with hand-computed results.
    issue(16'h0000, 16'h0001, 1'b0, 1, mk(16'hFFFF, 1'b1, 1'b0));
    issue(16'h8000, 16'h0001, 1'b0, 1, mk(16'h7FFF, 1'b0, 1'b1));
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1, mk(16'hFFFF, 1'b1, 1'b0));
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1, mk(16'h8000, 1'b1, 1'b1));
    issue(16'h0005, 16'h0003, 1'b1, 1, mk(16'h0001, 1'b0, 1'b0));
    issue(16'h0100, 16'h0001, 1'b0, 1, mk(16'h00FF, 1'b0, 1'b0));
    drain();

    // Backpressure: result held while out_ready stays low.
    @(negedge clk);
    mode = 2;
    issue(16'h5555, 16'h1111, 1'b0, 1, mk(16'h4444, 1'b0, 1'b0));
    t = 0;
    @(negedge clk);
    while (!sif.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      sif.in_valid = ~sif.in_valid;
      sif.a        = 16'($urandom);
      sif.b        = 16'($urandom);
      sif.bin      = 1'($urandom);
      @(negedge clk);
      check("bp_diff",      32'(sif.diff),      32'h4444);
      check("bp_bout",      32'(sif.bout),      32'd0);
      check("bp_ovf",       32'(sif.ovf),       32'd0);
      check("bp_in_ready",  32'(sif.in_ready),  32'd0);
      check("bp_out_valid", 32'(sif.out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    @(negedge clk);
    mode = 0;
    t = 0;
    @(negedge clk);
    while (!(sif.out_valid && sif.out_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready",  32'(sif.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(sif.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_no_capture", 32'(sif.in_ready), 32'd1);

    // Reset two cycles after accept aborts the operation.
    issue(16'h1234, 16'h0034, 1'b0, 0, mk(16'h0000, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(sif.in_ready),  32'd1);
    check("abort_out_valid", 32'(sif.out_valid), 32'd0);
    check("abort_busy",      32'(sif.busy),      32'd0);
    check("abort_diff",      32'(sif.diff),      32'd0);
    check("abort_bout",      32'(sif.bout),      32'd0);
    check("abort_ovf",       32'(sif.ovf),       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_abort_in_ready",  32'(sif.in_ready),  32'd1);
    check("post_abort_out_valid", 32'(sif.out_valid), 32'd0);
    issue(16'h1234, 16'h0034, 1'b0, 1, mk(16'h1200, 1'b0, 1'b0));
    drain();

    // Random back-to-back sweep with random consumer stalls.
    @(negedge clk);
    mode = 1;
    for (int i = 0; i < 10000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if ((i % 16) == 0) begin
        rb   = 16'hFFFF;
        rbin = 1'b1;
      end
      issue(ra, rb, rbin, 1, model(ra, rb, rbin));
    end
    drain();
    @(negedge clk);
    mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
